daccess_responder: RTL

- Memory-side end of the CPU data access interface; answers load/store requests issued by the core's MEM stage.
- Captures one request, waits a programmable latency, then returns one-cycle `daccess_valid` with `daccess_rdata`, or one-cycle `daccess_wresp`.
- Backed by an internal word-addressed RAM with byte-lane write enables.
- Serves as the data-memory model for core bring-up and as the template for the later bus bridge.

---
 rtl/daccess_pkg.sv | 26 ++
 rtl/daccess_if.sv | 30 +++
 rtl/daccess_ram.sv | 36 +++
 rtl/daccess_responder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/daccess_pkg.sv
// daccess_pkg -- shared types and constants for the data-access responder.
//   state_t    : responder FSM encoding (IDLE/BUSY/DONE, 2 bits)
//   REN_ALL    : value the core drives on daccess_ren for a load
//   LFSR_*     : seed, taps and step function of the optional random-latency
//                LFSR (only used when DACCESS_RAND_LAT_EN is defined)
//   CNT_W      : width of the latency counter (LATENCY-1 + 7 must fit)
package daccess_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]  REN_ALL   = 4'hF;
  localparam int          CNT_W     = 5;

  // Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/daccess_if.sv
// daccess_if -- CPU data-access bus between the core MEM stage (master) and
// the memory-side responder (slave).
//   daccess_ren   : read request, 4'hF when active
//   daccess_addr  : byte address
//   daccess_wen   : byte-lane write enables, nonzero = write
//   daccess_wdata : lane-aligned write data
//   daccess_valid : one-cycle read response, qualifies daccess_rdata
//   daccess_rdata : full-word read data
//   daccess_wresp : one-cycle write-complete pulse
//   busy          : responder is not idle
interface daccess_if;
  logic [3:0]  daccess_ren;
  logic [31:0] daccess_addr;
  logic [3:0]  daccess_wen;
  logic [31:0] daccess_wdata;
  logic        daccess_valid;
  logic [31:0] daccess_rdata;
  logic        daccess_wresp;
  logic        busy;

  modport master (
    output daccess_ren, daccess_addr, daccess_wen, daccess_wdata,
    input  daccess_valid, daccess_rdata, daccess_wresp, busy
  );

  modport slave (
    input  daccess_ren, daccess_addr, daccess_wen, daccess_wdata,
    output daccess_valid, daccess_rdata, daccess_wresp, busy
  );
endinterface

// File: rtl/daccess_ram.sv
// daccess_ram -- word array with synchronous byte-lane writes and a
// combinational read port. Each byte lane is its own array so a lane write
// never touches the other lanes.
//   clk   : write clock
//   we    : per-lane write enables
//   waddr : write word address
//   wdata : write data (lane i = wdata[8i+7:8i])
//   raddr : read word address
//   rdata : read data (combinational)
module daccess_ram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [0:(1<<AW)-1];

      always_ff @(posedge clk) begin
        if (we[gi]) begin
          lane_mem[waddr] <= wdata[8*gi +: 8];
        end
      end

      assign rdata[8*gi +: 8] = lane_mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/daccess_responder.sv
// daccess_responder -- memory-side end of the CPU data-access interface.
// Captures one load/store, waits LATENCY cycles, then pulses daccess_valid
// (with daccess_rdata) or daccess_wresp. Backed by daccess_ram.
//   cpu_clk : clock, posedge
//   cpu_rst : synchronous active-high reset (RAM contents are kept)
//   bus     : daccess_if.slave (request in, response/busy out)
// Optional build macro DACCESS_RAND_LAT_EN: adds 0..7 random cycles of
// latency per access from a free-running 16-bit LFSR.
module daccess_responder
  import daccess_pkg::*;
#(
  parameter int          AW_WORDS  = 14,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic     cpu_clk,
  input  logic     cpu_rst,
  daccess_if.slave bus
);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [31:0]        addr_reg;
  logic [31:0]        wdata_reg;
  logic [3:0]         wen_reg;
  logic               is_write_reg;
  logic               valid_reg;
  logic               wresp_reg;
  logic               busy_reg;
  logic [31:0]        rdata_reg;

  logic               req;
  logic [CNT_W-1:0]   load_cnt;
  logic               access_now;
  logic [31:0]        cur_addr;
  logic [31:0]        cur_wdata;
  logic [3:0]         cur_wen;
  logic               cur_is_write;
  logic [31:0]        off;
  logic               in_range;
  logic [AW_WORDS-1:0] word;
  logic [3:0]         ram_we;
  logic [31:0]        ram_rdata;
  logic               unused_off_bits;

  assign req = (bus.daccess_wen != 4'h0) || (bus.daccess_ren != 4'h0);

`ifdef DACCESS_RAND_LAT_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) lfsr_reg <= LFSR_SEED;
    else         lfsr_reg <= lfsr_step(lfsr_reg);
  end

  assign load_cnt = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_reg[2:0]);
`else
  assign load_cnt = CNT_W'(LATENCY - 1);
`endif

  // Outputs are registered, so the access itself happens one edge before
  // the response cycle: at the capture edge when no wait is needed, else at
  // the edge where the counter steps from 1 to 0. The cycle with counter 0
  // is the response cycle, followed by DONE which absorbs the release cycle.
  assign access_now = ((state_reg == IDLE) && req && (load_cnt == '0)) ||
                      ((state_reg == BUSY) && (cnt_reg == CNT_W'(1)));

  // In IDLE the request has not been latched yet; use the bus directly.
  assign cur_addr     = (state_reg == IDLE) ? bus.daccess_addr  : addr_reg;
  assign cur_wdata    = (state_reg == IDLE) ? bus.daccess_wdata : wdata_reg;
  assign cur_wen      = (state_reg == IDLE) ? bus.daccess_wen   : wen_reg;
  assign cur_is_write = (state_reg == IDLE) ? (bus.daccess_wen != 4'h0)
                                            : is_write_reg;

  // Unsigned subtraction: addresses below BASE_ADDR wrap and fall out of range.
  assign off             = cur_addr - BASE_ADDR;
  assign in_range        = (off[31:AW_WORDS+2] == '0);
  assign word            = off[AW_WORDS+1:2];
  assign unused_off_bits = ^off[1:0];

  // Reset on the commit edge aborts the write.
  assign ram_we = (access_now && cur_is_write && in_range && !cpu_rst)
                  ? cur_wen : 4'h0;

  daccess_ram #(.AW(AW_WORDS)) u_ram (
    .clk   (cpu_clk),
    .we    (ram_we),
    .waddr (word),
    .wdata (cur_wdata),
    .raddr (word),
    .rdata (ram_rdata)
  );

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wen_reg      <= '0;
      is_write_reg <= 1'b0;
      valid_reg    <= 1'b0;
      wresp_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      valid_reg <= access_now && !cur_is_write;
      wresp_reg <= access_now && cur_is_write;
      if (access_now && !cur_is_write) begin
        rdata_reg <= in_range ? ram_rdata : 32'h0;
      end

      case (state_reg)
        IDLE: begin
          if (req) begin
            addr_reg     <= bus.daccess_addr;
            wdata_reg    <= bus.daccess_wdata;
            wen_reg      <= bus.daccess_wen;
            is_write_reg <= (bus.daccess_wen != 4'h0);
            cnt_reg      <= load_cnt;
            state_reg    <= BUSY;
            busy_reg     <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_reg == '0) state_reg <= DONE;
          else               cnt_reg   <= cnt_reg - CNT_W'(1);
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.daccess_valid = valid_reg;
  assign bus.daccess_wresp = wresp_reg;
  assign bus.daccess_rdata = rdata_reg;
  assign bus.busy          = busy_reg;

endmodule
